// File: rtl/rat_pc_pkg.sv
//------------------------------------------------------------------------------
// Module : rat_pc_pkg
// Brief  : Shared constants and PC source select encoding for the RAT MCU PC.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package rat_pc_pkg;

  localparam int              ADDR_W   = 10;
  localparam logic [ADDR_W-1:0] INTR_VEC = 10'h3FF;

  typedef enum logic [1:0] {
    PC_FROM_IMMED = 2'd0,
    PC_FROM_STACK = 2'd1,
    PC_FROM_INTR  = 2'd2,
    PC_RSVD       = 2'd3
  } pc_sel_t;

endpackage

`default_nettype wire

// File: rtl/prog_counter_unit_ret_stack.sv
//------------------------------------------------------------------------------
// Module : ret_stack
// Brief  : Parameterised return-address LIFO with occupancy, flags and a
//          combinational misuse pulse (push-full, pop-empty, push+pop).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ret_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_top,
  output logic [LVL_W-1:0] o_level,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_err
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [LVL_W-1:0]   r_level;
  logic               w_empty;
  logic               w_full;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic [c_PTR_W-1:0] w_wr_idx;
  logic [c_PTR_W-1:0] w_top_idx;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  // A simultaneous push and pop is treated as misuse and performs neither.
  assign w_push_ok = i_push & ~i_pop & ~w_full;
  assign w_pop_ok  = i_pop & ~i_push & ~w_empty;
  assign w_wr_idx  = r_level[c_PTR_W-1:0];
  assign w_top_idx = c_PTR_W'(r_level - LVL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else if (w_push_ok) begin
      r_level <= r_level + LVL_W'(1);
    end else if (w_pop_ok) begin
      r_level <= r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

  assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
  assign o_level = r_level;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_err   = (i_push & i_pop) | (i_push & w_full) | (i_pop & w_empty);

endmodule

`default_nettype wire

// File: rtl/prog_counter_unit.sv
//------------------------------------------------------------------------------
// Module : prog_counter_unit
// Brief  : RAT MCU program counter with return-address stack and interrupt
//          vector. Optional jump trace enabled by defining PC_TRACE_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module prog_counter_unit #(
  parameter int                ADDR_W      = rat_pc_pkg::ADDR_W,
  parameter int                STACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] INTR_VEC    = rat_pc_pkg::INTR_VEC
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         PC_LD,
  input  logic                         PC_INC,
  input  logic [1:0]                   PC_SEL,
  input  logic [ADDR_W-1:0]            IMMED,
  input  logic                         PUSH,
  input  logic                         POP,
  output logic [ADDR_W-1:0]            PC_COUNT,
  output logic [$clog2(STACK_DEPTH):0] STK_LEVEL,
  output logic                         STK_EMPTY,
  output logic                         STK_FULL,
  output logic                         STK_ERR
`ifdef PC_TRACE_EN
  ,
  output logic                         TRACE_VLD,
  output logic [ADDR_W-1:0]            TRACE_FROM,
  output logic [ADDR_W-1:0]            TRACE_TO
`endif
);

  import rat_pc_pkg::*;

  localparam int c_LVL_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [ADDR_W-1:0]  w_stk_top;
  logic [c_LVL_W-1:0] w_stk_level;
  logic               w_stk_err;
  logic               r_stk_err;
  pc_sel_t            w_sel;

  assign w_sel = pc_sel_t'(PC_SEL);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W),
    .LVL_W (c_LVL_W)
  ) u_ret_stack (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (PUSH),
    .i_pop   (POP),
    .i_din   (r_pc),
    .o_top   (w_stk_top),
    .o_level (w_stk_level),
    .o_empty (STK_EMPTY),
    .o_full  (STK_FULL),
    .o_err   (w_stk_err)
  );

  // Top-of-stack is sampled before the pop lands, so RET returns the pushed PC.
  always_comb begin
    w_pc_next = r_pc;
    if (PC_LD) begin
      case (w_sel)
        PC_FROM_IMMED: w_pc_next = IMMED;
        PC_FROM_STACK: w_pc_next = w_stk_top;
        PC_FROM_INTR:  w_pc_next = INTR_VEC;
        default:       w_pc_next = '0;
      endcase
    end else if (PC_INC) begin
      w_pc_next = r_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc      <= '0;
      r_stk_err <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_stk_err) begin
        r_stk_err <= 1'b1;
      end
    end
  end

  assign PC_COUNT  = r_pc;
  assign STK_LEVEL = w_stk_level;
  assign STK_ERR   = r_stk_err;

`ifdef PC_TRACE_EN
  logic              r_trace_vld;
  logic [ADDR_W-1:0] r_trace_from;
  logic [ADDR_W-1:0] r_trace_to;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_trace_vld  <= 1'b0;
      r_trace_from <= '0;
      r_trace_to   <= '0;
    end else begin
      r_trace_vld <= PC_LD;
      if (PC_LD) begin
        r_trace_from <= r_pc;
        r_trace_to   <= w_pc_next;
      end
    end
  end

  assign TRACE_VLD  = r_trace_vld;
  assign TRACE_FROM = r_trace_from;
  assign TRACE_TO   = r_trace_to;
`endif

endmodule

`default_nettype wire
